// File: rtl/ts_submit_schedule_mc.sv
// Time-slot scheduler: walks a slot table on global-time ticks and submits addresses.
// Define SUBMIT_MISS_CNT_EN to count slot switches that arrive while a submit is pending.
module ts_submit_schedule_mc #(
    parameter int ADDR_W     = 5,
    parameter int TBL_AW     = 10,
    parameter int SLOT_LEN_W = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            iv_cfg_finish,
    input  logic [47:0]           iv_syned_global_time,
    input  logic [SLOT_LEN_W-1:0] iv_time_slot_length,
    input  logic [TBL_AW:0]       iv_table_period,
    input  logic [15:0]           iv_table_wdata,
    input  logic                  i_table_wr,
    input  logic [TBL_AW-1:0]     iv_table_addr,
    input  logic                  i_table_rd,
    output logic [15:0]           ov_table_rdata,
    output logic                  o_table_rdata_valid,
    output logic [ADDR_W-1:0]     ov_ts_submit_addr,
    output logic                  o_ts_submit_addr_wr,
    input  logic                  i_ts_submit_addr_ack,
    output logic [TBL_AW-1:0]     ov_time_slot,
    output logic [2:0]            ssm_state,
    output logic [15:0]           ov_submit_miss_cnt
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_READ   = 3'd2,
        S_WAIT   = 3'd3,
        S_SUBMIT = 3'd4
    } state_t;

    localparam logic [TBL_AW:0] DEPTH = {1'b1, {TBL_AW{1'b0}}};

    state_t                state;
    state_t                state_nxt;
    logic                  cfg_ok;
    logic [37:0]           time_q;
    logic                  primed;
    logic                  tick;
    logic                  slot_switch;
    logic [SLOT_LEN_W-1:0] tick_cnt;
    logic [SLOT_LEN_W-1:0] len_eff;
    logic [TBL_AW:0]       period_eff;
    logic [TBL_AW:0]       slot_inc;
    logic [15:0]           mem [0:(1<<TBL_AW)-1];
    logic [15:0]           rdata_a;
    logic [15:0]           rdata_b;
    logic                  rd_q;
    logic                  unused_bits;

    assign cfg_ok      = (iv_cfg_finish == 2'b11);
    assign ssm_state   = state;
    assign unused_bits = ^{rdata_b[14:ADDR_W], iv_syned_global_time[9:0]};

    // The first cycle after reset only captures time so a stale value cannot tick.
    assign tick        = primed && (iv_syned_global_time[47:10] != time_q);
    assign slot_switch = tick && (tick_cnt >= len_eff - SLOT_LEN_W'(1));
    assign slot_inc    = {1'b0, ov_time_slot} + (TBL_AW+1)'(1);

    always_comb begin
        len_eff = iv_time_slot_length;
        if (iv_time_slot_length == '0)
            len_eff = SLOT_LEN_W'(1);
    end

    always_comb begin
        period_eff = iv_table_period;
        if (iv_table_period == '0)
            period_eff = (TBL_AW+1)'(1);
        else if (iv_table_period > DEPTH)
            period_eff = DEPTH;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            time_q       <= '0;
            primed       <= 1'b0;
            tick_cnt     <= '0;
            ov_time_slot <= '0;
        end else begin
            time_q <= iv_syned_global_time[47:10];
            primed <= 1'b1;
            if (slot_switch) begin
                tick_cnt <= '0;
                // >= also catches a period shrunk below the current slot
                if (slot_inc >= period_eff)
                    ov_time_slot <= '0;
                else
                    ov_time_slot <= slot_inc[TBL_AW-1:0];
            end else if (tick) begin
                tick_cnt <= tick_cnt + SLOT_LEN_W'(1);
            end
        end
    end

    // Slot table: port A owns writes and config reads, port B feeds the scheduler.
    always_ff @(posedge i_clk) begin
        if (i_table_wr)
            mem[iv_table_addr] <= iv_table_wdata;
        rdata_a <= mem[iv_table_addr];
        if (state == S_READ)
            rdata_b <= mem[ov_time_slot];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_q                <= 1'b0;
            o_table_rdata_valid <= 1'b0;
            ov_table_rdata      <= '0;
        end else begin
            rd_q                <= i_table_rd && !i_table_wr;
            o_table_rdata_valid <= rd_q;
            if (rd_q)
                ov_table_rdata <= rdata_a;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!cfg_ok) begin
            state_nxt = S_INIT;
        end else begin
            unique case (state)
                S_INIT:   state_nxt = S_IDLE;
                S_IDLE:   if (slot_switch) state_nxt = S_READ;
                S_READ:   state_nxt = S_WAIT;
                S_WAIT:   state_nxt = rdata_b[15] ? S_SUBMIT : S_IDLE;
                S_SUBMIT: if (i_ts_submit_addr_ack)
                              state_nxt = slot_switch ? S_READ : S_IDLE;
                default:  state_nxt = S_INIT;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_ts_submit_addr   <= '0;
            o_ts_submit_addr_wr <= 1'b0;
        end else begin
            o_ts_submit_addr_wr <= (state_nxt == S_SUBMIT);
            if (state == S_WAIT && state_nxt == S_SUBMIT)
                ov_ts_submit_addr <= rdata_b[ADDR_W-1:0];
        end
    end

`ifdef SUBMIT_MISS_CNT_EN
    logic [15:0] miss_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            miss_cnt <= '0;
        else if (cfg_ok && state == S_SUBMIT && slot_switch &&
                 !i_ts_submit_addr_ack && miss_cnt != 16'hFFFF)
            miss_cnt <= miss_cnt + 16'd1;
    end

    assign ov_submit_miss_cnt = miss_cnt;
`else
    assign ov_submit_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_ts_submit_schedule_mc.sv
// Directed bench for ts_submit_schedule_mc: table readback vectors plus
// hand-written scheduling, miss, cfg-drop and async-reset sequences.
module tb_ts_submit_schedule_mc;

    logic        clk;
    logic        rst_n;
    logic [1:0]  cfg;
    logic [47:0] gtime;
    logic [10:0] slot_len;
    logic [10:0] period;
    logic [15:0] wdata;
    logic        twr;
    logic [9:0]  taddr;
    logic        trd;
    logic [15:0] rdata;
    logic        rvalid;
    logic [4:0]  sub_addr;
    logic        sub_wr;
    logic        ack;
    logic [9:0]  tslot;
    logic [2:0]  st;
    logic [15:0] miss;

    int total = 0;
    int bad   = 0;
    int exp_miss;
    int exp_slot;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [4];

    ts_submit_schedule_mc dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .iv_cfg_finish        (cfg),
        .iv_syned_global_time (gtime),
        .iv_time_slot_length  (slot_len),
        .iv_table_period      (period),
        .iv_table_wdata       (wdata),
        .i_table_wr           (twr),
        .iv_table_addr        (taddr),
        .i_table_rd           (trd),
        .ov_table_rdata       (rdata),
        .o_table_rdata_valid  (rvalid),
        .ov_ts_submit_addr    (sub_addr),
        .o_ts_submit_addr_wr  (sub_wr),
        .i_ts_submit_addr_ack (ack),
        .ov_time_slot         (tslot),
        .ssm_state            (st),
        .ov_submit_miss_cnt   (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act,
                       input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr_tbl(input logic [9:0] a, input logic [15:0] d);
        twr   = 1'b1;
        taddr = a;
        wdata = d;
        step();
        twr = 1'b0;
    endtask

    task automatic rd_tbl(input logic [9:0] a, input logic [15:0] exp,
                          input string name);
        trd   = 1'b1;
        taddr = a;
        step();
        trd = 1'b0;
        chk({name, "_valid_early"}, 48'(rvalid), 48'd0);
        step();
        chk({name, "_valid"}, 48'(rvalid), 48'd1);
        chk({name, "_data"}, 48'(rdata), 48'(exp));
        step();
        chk({name, "_valid_pulse"}, 48'(rvalid), 48'd0);
    endtask

    task automatic adv();
        gtime = gtime + 48'd1024;
        repeat (4) step();
    endtask

    initial begin
`ifdef SUBMIT_MISS_CNT_EN
        exp_miss = 2;
`else
        exp_miss = 0;
`endif
        vecs[0] = '{10'd5,    16'hABCD, 16'hABCD};
        vecs[1] = '{10'd0,    16'h0000, 16'h0000};
        vecs[2] = '{10'd1023, 16'hFFFF, 16'hFFFF};
        vecs[3] = '{10'd512,  16'h1234, 16'h1234};

        rst_n    = 1'b0;
        cfg      = 2'b00;
        gtime    = 48'd5 * 48'd1024;
        slot_len = 11'd1;
        period   = 11'd2;
        wdata    = '0;
        twr      = 1'b0;
        taddr    = '0;
        trd      = 1'b0;
        ack      = 1'b0;
        step();
        chk("rst_state", 48'(st), 48'd0);
        chk("rst_slot", 48'(tslot), 48'd0);
        chk("rst_addr", 48'(sub_addr), 48'd0);
        chk("rst_wr", 48'(sub_wr), 48'd0);
        chk("rst_rdata", 48'(rdata), 48'd0);
        chk("rst_rvalid", 48'(rvalid), 48'd0);
        chk("rst_miss", 48'(miss), 48'd0);

        rst_n = 1'b1;
        repeat (3) step();
        chk("first_sample_no_adv", 48'(tslot), 48'd0);

        foreach (vecs[i]) wr_tbl(vecs[i].addr, vecs[i].wdata);
        foreach (vecs[i]) rd_tbl(vecs[i].addr, vecs[i].exp, $sformatf("tbl%0d", i));

        twr   = 1'b1;
        trd   = 1'b1;
        taddr = 10'd5;
        wdata = 16'h5A5A;
        step();
        twr = 1'b0;
        trd = 1'b0;
        repeat (3) begin
            step();
            chk("rdwr_no_valid", 48'(rvalid), 48'd0);
        end
        rd_tbl(10'd5, 16'h5A5A, "rdwr_write_won");

        wr_tbl(10'd0, 16'h8003);
        wr_tbl(10'd1, 16'h0000);
        cfg = 2'b11;
        step();
        chk("init_to_idle", 48'(st), 48'd1);
        for (int i = 0; i < 4; i++) begin
            exp_slot = (i % 2 == 0) ? 1 : 0;
            gtime = gtime + 48'd1024;
            step();
            chk("sched_slot", 48'(tslot), 48'(exp_slot));
            chk("sched_read", 48'(st), 48'd2);
            step();
            chk("sched_wait", 48'(st), 48'd3);
            step();
            if (exp_slot == 0) begin
                chk("sched_wr", 48'(sub_wr), 48'd1);
                chk("sched_addr", 48'(sub_addr), 48'd3);
                step();
                chk("sched_wr_hold", 48'(sub_wr), 48'd1);
                ack = 1'b1;
                step();
                ack = 1'b0;
                chk("sched_wr_drop", 48'(sub_wr), 48'd0);
                chk("sched_idle", 48'(st), 48'd1);
            end else begin
                chk("sched_no_wr", 48'(sub_wr), 48'd0);
                chk("sched_invalid_idle", 48'(st), 48'd1);
            end
        end

        wr_tbl(10'd0, 16'h0000);
        wr_tbl(10'd2, 16'h0000);
        wr_tbl(10'd3, 16'h0000);
        period = 11'd4;
        adv();
        adv();
        adv();
        chk("per4_slot3", 48'(tslot), 48'd3);
        period = 11'd2;
        adv();
        chk("per_shrink_wrap", 48'(tslot), 48'd0);
        slot_len = 11'd0;
        adv();
        chk("len0_slot1", 48'(tslot), 48'd1);
        adv();
        chk("len0_slot0", 48'(tslot), 48'd0);
        slot_len = 11'd2;
        adv();
        chk("len2_hold", 48'(tslot), 48'd0);
        adv();
        chk("len2_adv", 48'(tslot), 48'd1);
        slot_len = 11'd1;
        period   = 11'd0;
        adv();
        chk("per0_wrap", 48'(tslot), 48'd0);
        adv();
        chk("per0_stay", 48'(tslot), 48'd0);
        period = 11'd2;

        wr_tbl(10'd0, 16'h8001);
        wr_tbl(10'd1, 16'h8001);
        gtime = gtime + 48'd1024;
        repeat (3) step();
        chk("miss_wr", 48'(sub_wr), 48'd1);
        chk("miss_addr", 48'(sub_addr), 48'd1);
        for (int s = 0; s < 2; s++) begin
            gtime = gtime + 48'd1024;
            repeat (4) begin
                step();
                chk("miss_hold_wr", 48'(sub_wr), 48'd1);
                chk("miss_hold_addr", 48'(sub_addr), 48'd1);
            end
        end
        chk("miss_cnt", 48'(miss), 48'(exp_miss));
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("miss_ack_drop", 48'(sub_wr), 48'd0);
        chk("miss_ack_idle", 48'(st), 48'd1);

        gtime = gtime + 48'd1024;
        repeat (3) step();
        chk("coin_wr", 48'(sub_wr), 48'd1);
        gtime = gtime + 48'd1024;
        ack   = 1'b1;
        step();
        ack = 1'b0;
        chk("coin_read", 48'(st), 48'd2);
        chk("coin_wr_drop", 48'(sub_wr), 48'd0);
        chk("coin_no_miss", 48'(miss), 48'(exp_miss));
        step();
        step();
        chk("coin_resubmit", 48'(sub_wr), 48'd1);

        cfg = 2'b01;
        step();
        chk("cfg_drop_init", 48'(st), 48'd0);
        chk("cfg_drop_wr", 48'(sub_wr), 48'd0);
        cfg = 2'b11;
        step();
        chk("cfg_back_idle", 48'(st), 48'd1);
        gtime = gtime + 48'd1024;
        repeat (3) step();
        chk("cfg_resume_wr", 48'(sub_wr), 48'd1);
        chk("cfg_resume_st", 48'(st), 48'd4);

        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 48'(st), 48'd0);
        chk("arst_wr", 48'(sub_wr), 48'd0);
        chk("arst_addr", 48'(sub_addr), 48'd0);
        chk("arst_slot", 48'(tslot), 48'd0);
        chk("arst_miss", 48'(miss), 48'd0);
        chk("arst_rdata", 48'(rdata), 48'd0);
        step();
        rst_n = 1'b1;
        step();
        rd_tbl(10'd0, 16'h8001, "arst_ram_kept");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
